// File: rtl/calc1_pkg.sv
// Shared encodings for the calc1 scheduler: commands, responses and the
// per-port capture FSM states.
package calc1_pkg;
  localparam logic [3:0] CMD_NOP = 4'd0;
  localparam logic [3:0] CMD_ADD = 4'd1;
  localparam logic [3:0] CMD_SUB = 4'd2;
  localparam logic [3:0] CMD_SHL = 4'd5;
  localparam logic [3:0] CMD_SHR = 4'd6;

  localparam logic [1:0] RESP_NONE = 2'd0;
  localparam logic [1:0] RESP_OK   = 2'd1;
  localparam logic [1:0] RESP_ERR  = 2'd2;

  typedef enum logic [1:0] {ST_IDLE, ST_OP2, ST_PEND, ST_FLIGHT} port_state_e;

  function automatic logic is_valid_cmd(input logic [3:0] cmd);
    return (cmd == CMD_ADD) || (cmd == CMD_SUB) || (cmd == CMD_SHL) || (cmd == CMD_SHR);
  endfunction
endpackage

// File: rtl/calc1_port_ctrl.sv
// One requester port: captures cmd/op1/op2, waits for a grant, then drives a
// one-cycle response when its tag comes back from the ALU.
module calc1_port_ctrl
  import calc1_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic          c_clk,
  input  logic          reset,
  input  logic [3:0]    req_cmd,
  input  logic [DW-1:0] req_data,
  input  logic          grant,
  input  logic          rsp_hit,
  input  logic [1:0]    alu_resp,
  input  logic [DW-1:0] alu_result,
  output logic          pend,
  output logic [3:0]    cmd,
  output logic [DW-1:0] op1,
  output logic [DW-1:0] op2,
  output logic [1:0]    out_resp,
  output logic [DW-1:0] out_data
);
  port_state_e   state_q, state_d;
  logic [3:0]    cmd_q, cmd_d;
  logic [DW-1:0] op1_q, op1_d, op2_q, op2_d, data_q, data_d;
  logic [1:0]    resp_q, resp_d;

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    op1_d   = op1_q;
    op2_d   = op2_q;
    data_d  = data_q;
    resp_d  = RESP_NONE;
    case (state_q)
      // Only IDLE looks at req_cmd, so a command to a busy port is dropped.
      ST_IDLE: if (req_cmd != CMD_NOP) begin
        state_d = ST_OP2;
        cmd_d   = req_cmd;
        op1_d   = req_data;
      end
      ST_OP2: begin
        op2_d = req_data;
        if (is_valid_cmd(cmd_q)) begin
          state_d = ST_PEND;
        end else begin
          state_d = ST_IDLE;
          resp_d  = RESP_ERR;
          data_d  = '0;
        end
      end
      ST_PEND: if (grant) state_d = ST_FLIGHT;
      ST_FLIGHT: if (rsp_hit) begin
        state_d = ST_IDLE;
        resp_d  = alu_resp;
        data_d  = alu_result;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge c_clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cmd_q   <= '0;
      op1_q   <= '0;
      op2_q   <= '0;
      data_q  <= '0;
      resp_q  <= RESP_NONE;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      data_q  <= data_d;
      resp_q  <= resp_d;
    end
  end

  assign pend     = (state_q == ST_PEND);
  assign cmd      = cmd_q;
  assign op1      = op1_q;
  assign op2      = op2_q;
  assign out_resp = resp_q;
  assign out_data = data_q;
endmodule

// File: rtl/calc1_scheduler.sv
// Shares one calc1 ALU between NPORTS requesters: round-robin issue and a
// tag pipeline that routes each ALU result back to its port.
module calc1_scheduler
  import calc1_pkg::*;
#(
  parameter int NPORTS  = 4,
  parameter int DW      = 32,
  parameter int ALU_LAT = 2
) (
  input  logic                 c_clk,
  input  logic                 reset,
  input  logic [4*NPORTS-1:0]  req_cmd_in,
  input  logic [DW*NPORTS-1:0] req_data_in,
  output logic [2*NPORTS-1:0]  out_resp,
  output logic [DW*NPORTS-1:0] out_data,
  output logic                 alu_valid,
  output logic [3:0]           alu_cmd,
  output logic [DW-1:0]        alu_op1,
  output logic [DW-1:0]        alu_op2,
  input  logic [1:0]           alu_resp,
  input  logic [DW-1:0]        alu_result
);
  localparam int PW = $clog2(NPORTS);

  logic [NPORTS-1:0]          pend, grant, rsp_hit;
  logic [NPORTS-1:0][3:0]     p_cmd;
  logic [NPORTS-1:0][DW-1:0]  p_op1, p_op2;
  logic [PW-1:0]              rr_q, rr_d, gnt_idx, cand;
  logic                       gnt_any;
  logic [ALU_LAT-1:0]         tag_vld_q, tag_vld_d;
  logic [ALU_LAT-1:0][PW-1:0] tag_idx_q, tag_idx_d;

  for (genvar gi = 0; gi < NPORTS; gi++) begin : g_port
    calc1_port_ctrl #(.DW(DW)) u_port (
      .c_clk      (c_clk),
      .reset      (reset),
      .req_cmd    (req_cmd_in[4*gi +: 4]),
      .req_data   (req_data_in[DW*gi +: DW]),
      .grant      (grant[gi]),
      .rsp_hit    (rsp_hit[gi]),
      .alu_resp   (alu_resp),
      .alu_result (alu_result),
      .pend       (pend[gi]),
      .cmd        (p_cmd[gi]),
      .op1        (p_op1[gi]),
      .op2        (p_op2[gi]),
      .out_resp   (out_resp[2*gi +: 2]),
      .out_data   (out_data[DW*gi +: DW])
    );
  end

  // rr_q is the first port searched this cycle, i.e. one past the last grant.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = rr_q;
    cand    = rr_q;
    for (int i = 0; i < NPORTS; i++) begin
      cand = PW'((int'(rr_q) + i) % NPORTS);
      if (!gnt_any && !reset && pend[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = cand;
      end
    end
    grant = '0;
    if (gnt_any) grant[gnt_idx] = 1'b1;
    rr_d = rr_q;
    if (gnt_any) rr_d = (gnt_idx == PW'(NPORTS-1)) ? '0 : gnt_idx + 1'b1;
  end

  assign alu_valid = gnt_any;
  assign alu_cmd   = gnt_any ? p_cmd[gnt_idx] : '0;
  assign alu_op1   = gnt_any ? p_op1[gnt_idx] : '0;
  assign alu_op2   = gnt_any ? p_op2[gnt_idx] : '0;

  always_comb begin
    tag_vld_d    = tag_vld_q;
    tag_idx_d    = tag_idx_q;
    tag_vld_d[0] = gnt_any;
    tag_idx_d[0] = gnt_idx;
    for (int i = 1; i < ALU_LAT; i++) begin
      tag_vld_d[i] = tag_vld_q[i-1];
      tag_idx_d[i] = tag_idx_q[i-1];
    end
    rsp_hit = '0;
    if (tag_vld_q[ALU_LAT-1]) rsp_hit[tag_idx_q[ALU_LAT-1]] = 1'b1;
  end

  always_ff @(posedge c_clk) begin
    if (reset) begin
      rr_q      <= '0;
      tag_vld_q <= '0;
      tag_idx_q <= '0;
    end else begin
      rr_q      <= rr_d;
      tag_vld_q <= tag_vld_d;
      tag_idx_q <= tag_idx_d;
    end
  end
endmodule

// File: tb/tb_calc1_scheduler.sv
// Directed bench for calc1_scheduler with a two-cycle pipelined ALU model.
module tb_calc1_scheduler;
  localparam int NP = 4;
  localparam int DW = 32;

  logic               c_clk = 1'b0;
  logic               reset;
  logic [4*NP-1:0]    req_cmd_in;
  logic [DW*NP-1:0]   req_data_in;
  logic [2*NP-1:0]    out_resp;
  logic [DW*NP-1:0]   out_data;
  logic               alu_valid;
  logic [3:0]         alu_cmd;
  logic [DW-1:0]      alu_op1, alu_op2;
  logic [1:0]         alu_resp;
  logic [DW-1:0]      alu_result;

  int n_chk = 0;
  int n_err = 0;

  calc1_scheduler #(.NPORTS(NP), .DW(DW), .ALU_LAT(2)) dut (
    .c_clk(c_clk), .reset(reset), .req_cmd_in(req_cmd_in), .req_data_in(req_data_in),
    .out_resp(out_resp), .out_data(out_data), .alu_valid(alu_valid), .alu_cmd(alu_cmd),
    .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_resp(alu_resp), .alu_result(alu_result)
  );

  always #5 c_clk = ~c_clk;

  // ALU model: result available two cycles after the issue cycle.
  logic [1:0]    m_resp, s0_resp = 2'd0, s1_resp = 2'd0;
  logic [DW-1:0] m_res,  s0_res = '0,   s1_res = '0;
  always_comb begin
    m_resp = 2'd0;
    m_res  = '0;
    if (alu_valid) begin
      case (alu_cmd)
        4'd1: begin m_resp = 2'd1; m_res = alu_op1 + alu_op2; end
        4'd2: begin m_resp = (alu_op2 > alu_op1) ? 2'd2 : 2'd1; m_res = alu_op1 - alu_op2; end
        4'd5: begin m_resp = 2'd1; m_res = alu_op1 << alu_op2[4:0]; end
        4'd6: begin m_resp = 2'd1; m_res = alu_op1 >> alu_op2[4:0]; end
        default: m_resp = 2'd2;
      endcase
    end
  end
  always @(posedge c_clk) begin
    s0_resp <= m_resp;  s0_res <= m_res;
    s1_resp <= s0_resp; s1_res <= s0_res;
  end
  assign alu_resp   = s1_resp;
  assign alu_result = s1_res;

  task automatic step();
    @(posedge c_clk);
    #1;
  endtask

  task automatic drv(input int p, input logic [3:0] c, input logic [DW-1:0] d);
    req_cmd_in[4*p +: 4]    = c;
    req_data_in[DW*p +: DW] = d;
  endtask

  function automatic logic [1:0] rsp(input int p);
    return out_resp[2*p +: 2];
  endfunction

  function automatic logic [DW-1:0] rdat(input int p);
    return out_data[DW*p +: DW];
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Uncontended request: issue at N, expect grant at N+2 and response at N+5.
  task automatic single(input string tag, input int p, input logic [3:0] c,
                        input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic [1:0] er, input logic [DW-1:0] ed);
    step(); drv(p, c, a);
    step(); drv(p, 4'd0, b); chk({tag, "_n1_valid"}, alu_valid, 0);
    step(); drv(p, 4'd0, 0);
    chk({tag, "_valid"}, alu_valid, 1);
    chk({tag, "_cmd"}, alu_cmd, c);
    chk({tag, "_op1"}, alu_op1, a);
    chk({tag, "_op2"}, alu_op2, b);
    step(); step(); chk({tag, "_n4_resp"}, rsp(p), 0);
    step();
    chk({tag, "_resp"}, rsp(p), er);
    chk({tag, "_data"}, rdat(p), ed);
    step();
    chk({tag, "_resp_clr"}, rsp(p), 0);
    chk({tag, "_data_hold"}, rdat(p), ed);
    step(); step();
  endtask

  initial begin
    int gp, expg, n_av, n_r;
    int iss[NP], nrsp[NP], ph[NP], last[NP], pst[NP];
    bit done;

    reset = 1'b1; req_cmd_in = '0; req_data_in = '0;
    step(); step();
    reset = 1'b0;
    step();
    chk("rst_out_resp", out_resp, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_alu_valid", alu_valid, 0);
    chk("rst_alu_cmd", alu_cmd, 0);
    chk("rst_alu_ops", {alu_op1, alu_op2}, 0);

    // All four ports issue together: grants 0..3 at N+2..N+5, responses N+5..N+8.
    step(); for (int p = 0; p < NP; p++) drv(p, 4'd1, 10*p + 1);
    step(); for (int p = 0; p < NP; p++) drv(p, 4'd0, p + 2);
    for (int c = 2; c <= 8; c++) begin
      step();
      if (c == 2) for (int p = 0; p < NP; p++) drv(p, 4'd0, 0);
      if (c <= 5) begin
        chk("sim_grant_valid", alu_valid, 1);
        chk("sim_grant_op1", alu_op1, 10*(c-2) + 1);
      end else chk("sim_no_grant", alu_valid, 0);
      if (c >= 5) begin
        chk("sim_resp", rsp(c-5), 1);
        chk("sim_data", rdat(c-5), 11*(c-5) + 3);
      end
    end
    step(); step();

    single("add", 0, 4'd1, 5, 7, 2'd1, 12);

    // Ports 1 and 3 re-issue as soon as each response appears.
    for (int p = 0; p < NP; p++) begin iss[p] = 0; nrsp[p] = 0; ph[p] = 0; last[p] = 0; pst[p] = 0; end
    expg = 1; done = 0;
    for (int t = 0; t < 400 && !done; t++) begin
      step();
      if (alu_valid) begin
        gp = int'(alu_op1) / 1000;
        chk("rr_order", gp, expg);
        chk("rr_wait_le3", (t - pst[gp]) <= 3, 1);
        expg = (expg == 1) ? 3 : 1;
      end
      for (int p = 1; p < NP; p += 2) begin
        if (rsp(p) != 2'd0) begin
          chk("rr_resp", rsp(p), 1);
          chk("rr_data", rdat(p), last[p] + 1);
          nrsp[p]++;
          ph[p] = 0;
        end
      end
      for (int p = 1; p < NP; p += 2) begin
        case (ph[p])
          0: if (iss[p] < 20) begin
               last[p] = p*1000 + iss[p];
               drv(p, 4'd1, last[p]);
               iss[p]++;
               ph[p] = 1;
             end else drv(p, 4'd0, 0);
          1: begin drv(p, 4'd0, 1); pst[p] = t + 1; ph[p] = 2; end
          default: drv(p, 4'd0, 0);
        endcase
      end
      done = (nrsp[1] == 20) && (nrsp[3] == 20);
    end
    chk("rr_complete", done, 1);
    step(); step();

    // Invalid command: error response at N+2, ALU never used.
    n_av = 0;
    for (int c = 0; c <= 5; c++) begin
      step();
      case (c)
        0: drv(2, 4'd4, 1);
        1: drv(2, 4'd0, 1);
        default: drv(2, 4'd0, 0);
      endcase
      n_av += int'(alu_valid);
      if (c == 2) begin
        chk("inv_resp", rsp(2), 2);
        chk("inv_data", rdat(2), 0);
      end
      if (c == 3) chk("inv_resp_clr", rsp(2), 0);
    end
    chk("inv_no_issue", n_av, 0);

    // Busy port: second command at N+3 must be ignored.
    n_av = 0; n_r = 0;
    for (int c = 0; c <= 12; c++) begin
      step();
      case (c)
        0: drv(1, 4'd2, 10);
        1: drv(1, 4'd0, 3);
        3: drv(1, 4'd1, 99);
        4: drv(1, 4'd0, 55);
        default: drv(1, 4'd0, 0);
      endcase
      n_av += int'(alu_valid);
      if (rsp(1) != 2'd0) begin
        n_r++;
        chk("busy_resp", rsp(1), 1);
        chk("busy_data", rdat(1), 7);
        chk("busy_resp_cycle", c, 5);
      end
    end
    chk("busy_issue_cnt", n_av, 1);
    chk("busy_resp_cnt", n_r, 1);

    single("sub_err", 0, 4'd2, 3, 10, 2'd2, 32'hFFFF_FFF9);
    single("shl", 3, 4'd5, 3, 4, 2'd1, 48);

    // Reset one cycle after the grant: the late ALU result must be dropped.
    step(); drv(0, 4'd1, 1);
    step(); drv(0, 4'd0, 2);
    step(); drv(0, 4'd0, 0); chk("rstm_grant", alu_valid, 1);
    step(); reset = 1'b1;
    step(); reset = 1'b0;
    chk("rstm_alu_resp_seen", alu_resp, 1);
    chk("rstm_data_clr", rdat(0), 0);
    n_r = 0;
    for (int c = 0; c < 8; c++) begin
      if (out_resp != '0) n_r++;
      if (alu_valid) n_r++;
      step();
    end
    chk("rstm_silent", n_r, 0);
    single("post_rst", 0, 4'd1, 20, 22, 2'd1, 42);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
